// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined IEEE-754 single-precision multiplier, flush-to-zero, no NaN.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   en                 pipeline advance; 0 freezes every stage
//   in_valid, x, y     new operand pair this cycle
//   tag_in             tag travelling with the operation
//   out_valid, res     completed product
//   tag_out            tag of the completed product
module fmul_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             in_valid,
    input  logic [31:0]      x,
    input  logic [31:0]      y,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic [31:0]      res,
    output logic [TAG_W-1:0] tag_out
);
    // stage 1: unpack, classify, exponent sum
    logic             v1_q, s1_q, z1_q, inf1_q;
    logic [TAG_W-1:0] tag1_q;
    logic signed [9:0] e1_q, e1_d;
    logic [23:0]      ma1_q, mb1_q;
    // stage 2: product, normalise
    logic             v2_q, s2_q, z2_q, inf2_q, g2_q, st2_q;
    logic             g2_d, st2_d;
    logic [TAG_W-1:0] tag2_q;
    logic signed [9:0] e2_q, e2_d;
    logic [22:0]      m2_q, m2_d;
    // stage 3: round, pack
    logic             v3_q;
    logic [TAG_W-1:0] tag3_q;
    logic [31:0]      res3_q, res3_d;
    logic [47:0]      p;
    logic             inc;
    logic [23:0]      mr;
    logic signed [9:0] ef;

    assign e1_d  = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
    assign p     = 48'(ma1_q) * 48'(mb1_q);
    assign m2_d  = p[47] ? p[46:24] : p[45:23];
    assign g2_d  = p[47] ? p[23] : p[22];
    assign st2_d = p[47] ? |p[22:0] : |p[21:0];
    assign e2_d  = e1_q + $signed({9'b0, p[47]});
    assign inc   = g2_q & (st2_q | m2_q[0]);
    // an all-ones mantissa rounding up leaves mr[22:0]=0 and carries into the exponent
    assign mr    = {1'b0, m2_q} + {23'b0, inc};
    assign ef    = e2_q + $signed({9'b0, mr[23]});
    // zero beats inf so inf*0 gives signed zero; underflow always gives +0
    assign res3_d = z2_q               ? {s2_q, 31'b0} :
                    inf2_q             ? {s2_q, 8'hff, 23'b0} :
                    (ef >= 10'sd255)   ? {s2_q, 8'hff, 23'b0} :
                    (ef <= 10'sd0)     ? 32'h0 :
                                         {s2_q, ef[7:0], mr[22:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            z1_q   <= 1'b0;
            inf1_q <= 1'b0;
            tag1_q <= '0;
            e1_q   <= '0;
            ma1_q  <= '0;
            mb1_q  <= '0;
            v2_q   <= 1'b0;
            s2_q   <= 1'b0;
            z2_q   <= 1'b0;
            inf2_q <= 1'b0;
            g2_q   <= 1'b0;
            st2_q  <= 1'b0;
            tag2_q <= '0;
            e2_q   <= '0;
            m2_q   <= '0;
            v3_q   <= 1'b0;
            tag3_q <= '0;
            res3_q <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            s1_q   <= x[31] ^ y[31];
            z1_q   <= (x[30:23] == 8'h00) | (y[30:23] == 8'h00);
            inf1_q <= (x[30:23] == 8'hff) | (y[30:23] == 8'hff);
            tag1_q <= tag_in;
            e1_q   <= e1_d;
            ma1_q  <= {1'b1, x[22:0]};
            mb1_q  <= {1'b1, y[22:0]};
            v2_q   <= v1_q;
            s2_q   <= s1_q;
            z2_q   <= z1_q;
            inf2_q <= inf1_q;
            g2_q   <= g2_d;
            st2_q  <= st2_d;
            tag2_q <= tag1_q;
            e2_q   <= e2_d;
            m2_q   <= m2_d;
            v3_q   <= v2_q;
            tag3_q <= tag2_q;
            res3_q <= res3_d;
        end
    end

    assign out_valid = v3_q;
    assign res       = res3_q;
    assign tag_out   = tag3_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe with directed, hand-computed vectors.
module tb_fmul_pipe;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn, en, in_valid;
    logic [31:0]      x, y, exp_d;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag_out;

    typedef struct {
        logic [31:0]      r;
        logic [TAG_W-1:0] t;
        int               due;
    } item_t;
    item_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cnt = 0;
    logic last_rst = 1'b1;
    logic last_en = 1'b1;
    logic             snap_v = 1'b0;
    logic [31:0]      snap_r = '0;
    logic [TAG_W-1:0] snap_t = '0;

    fmul_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid),
        .x(x), .y(y), .tag_in(tag_in),
        .out_valid(out_valid), .res(res), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // stimulus is accepted on an en edge; push the expected result with its due en-count
    always @(posedge clk) begin
        last_rst = !rstn;
        last_en  = en;
        if (!rstn) begin
            q.delete();
        end else if (en) begin
            cnt++;
            if (in_valid) q.push_back('{r: exp_d, t: tag_in, due: cnt + 2});
        end
    end

    always @(negedge clk) begin
        item_t it;
        if (last_rst) begin
            chk("reset_valid", 32'(out_valid), 32'd0);
            chk("reset_res", res, 32'd0);
            chk("reset_tag", 32'(tag_out), 32'd0);
        end else if (!last_en) begin
            chk("stall_valid", 32'(out_valid), 32'(snap_v));
            chk("stall_res", res, snap_r);
            chk("stall_tag", 32'(tag_out), 32'(snap_t));
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                it = q.pop_front();
                chk("res", res, it.r);
                chk("tag", 32'(tag_out), 32'(it.t));
                chk("latency", 32'(cnt), 32'(it.due));
            end
        end
        snap_v = out_valid;
        snap_r = res;
        snap_t = tag_out;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic [31:0] e);
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; x = a; y = b; tag_in = t; exp_d = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b1; in_valid = 1'b0; x = 32'h0; y = 32'h0; tag_in = '0; exp_d = 32'h0;
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; in_valid = 1'b0;
        x = 32'h0; y = 32'h0; tag_in = '0; exp_d = 32'h0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        issue(32'h3FC00000, 32'h40000000, 5'd3, 32'h40400000);
        idle(5);
        issue(32'h3F800000, 32'h3F800000, 5'd1, 32'h3F800000);
        issue(32'hBF800000, 32'h40000000, 5'd2, 32'hC0000000);
        issue(32'h3F800001, 32'h3F800001, 5'd3, 32'h3F800002);
        idle(4);
        issue(32'h3F800001, 32'h3FC00000, 5'd4, 32'h3FC00002);
        issue(32'h3F800001, 32'h3F800000, 5'd5, 32'h3F800001);
        issue(32'h7F000000, 32'h40000000, 5'd6, 32'h7F800000);
        issue(32'hFF000000, 32'h40000000, 5'd7, 32'hFF800000);
        issue(32'h00800000, 32'h3F000000, 5'd8, 32'h00000000);
        issue(32'h80000000, 32'h40400000, 5'd9, 32'h80000000);
        issue(32'h7F800000, 32'h00000000, 5'd10, 32'h00000000);
        issue(32'h40400000, 32'h40400000, 5'd11, 32'h41100000);
        issue(32'h7F800000, 32'h40000000, 5'd12, 32'h7F800000);
        issue(32'hFFFFFFFF, 32'h3F800000, 5'd13, 32'hFF800000);
        issue(32'h3F800000, 32'h40400000, 5'd14, 32'h40400000);
        repeat (4) begin
            @(negedge clk);
            en = 1'b0; in_valid = 1'b1; x = 32'h40000000; y = 32'h40000000; tag_in = 5'd31; exp_d = 32'hDEADBEEF;
        end
        issue(32'hBF800000, 32'hBF800000, 5'd15, 32'h3F800000);
        issue(32'h40000000, 32'h40000000, 5'd16, 32'h40800000);
        idle(5);
        issue(32'h3F800000, 32'h3F800000, 5'd20, 32'h3F800000);
        issue(32'h40000000, 32'h40000000, 5'd21, 32'h40800000);
        @(negedge clk);
        in_valid = 1'b0; rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        issue(32'h40400000, 32'h40000000, 5'd22, 32'h40C00000);
        idle(8);
        chk("drain_pending", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Fully pipelined single-precision multiplier; arithmetic counterpart of the pipelined divider in the long-latency FPU group.
- Accepts one operand pair per cycle and produces x*y after a fixed latency.
- Carries a valid bit and an instruction tag so the FPU writeback stage can match results to issued ops.
- Flush-to-zero, no NaN, same exception policy as the divider.

Parameters:
TAG_W, 5, width of the tag carried alongside each operation

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
en  input  1  pipeline advance; 0 freezes every stage
in_valid  input  1  x, y, tag_in hold a new operation this cycle
x  input  32  multiplicand, IEEE-754 single
y  input  32  multiplier, IEEE-754 single
tag_in  input  TAG_W  tag issued with the operation
out_valid  output  1  res, tag_out hold a completed result
res  output  32  product
tag_out  output  TAG_W  tag of the completed result

Behaviour:
- Reset: rstn is synchronous and active-low, clock is clk. While rstn=0, every pipeline register clears on the clk edge. out_valid=0, res=0, tag_out=0.
- Reset mid-operation discards all in-flight operations; no result emerges for them.
- Latency: exactly 3 en-cycles. An operation sampled on edge N (en=1) appears on the outputs after edge N+2 (en=1 on each edge), registered.
- Throughput: 1 operation per cycle.
- en=0: all stage registers, including valid and tag, hold their values. Inputs are ignored that cycle. Outputs are stable.
- in_valid=0 launches a bubble; out_valid follows the bubble 3 cycles later. Datapath registers may update for bubbles; res is don't-care when out_valid=0.
- Stage 1:
  - Unpack and compute s = sx^sy.
  - Zero/inf flags: exp==0 means zero (subnormals flushed); exp==255 means inf.
  - Exponent sum e = ex + ey - 127, 10-bit signed.
  - Start the 24x24 mantissa product with hidden bit 1; splitting into partial products registered here is allowed.
- Stage 2:
  - Complete the 48-bit product p.
  - If p[47]=1: m=p[46:24], guard=p[23], sticky=|p[22:0], e=e+1.
  - Otherwise: m=p[45:23], guard=p[22], sticky=|p[21:0].
- Stage 3, round and pack:
  - Round to nearest even: increment m when guard & (sticky | m[0]).
  - Mantissa carry-out: m=0, e=e+1.
- Special cases, in priority order:
  1. x or y zero, including inf*0: res = {s, 31'b0}.
  2. x or y inf: res = {s, 8'hff, 23'b0}.
  3. Final e >= 255: overflow, res = {s, 8'hff, 23'b0}.
  4. Final e <= 0: underflow, res = 32'h00000000 (positive zero, no subnormal output).
  5. Otherwise: res = {s, e[7:0], m}.
- NaN inputs are treated as inf. No exception flags.
- tag_in travels unmodified and stays aligned with its operation through all 3 stages.

Test Plan:
- Basic product: reset for 2 cycles, then in_valid=1, x=3FC00000, y=40000000, tag 3 -> 3 edges later out_valid=1, res=40400000, tag_out=3. out_valid=0 before that and after, with in_valid low afterwards.
- Back-to-back stream with tags 1,2,3: (3F800000*3F800000), (BF800000*40000000), (3F800001*3F800001) -> consecutive cycles res=3F800000, C0000000, 3F800002 with tags 1,2,3.
- Rounding tie to nearest even: 3F800001*3FC00000 -> 3FC00002. 3F800001*3F800000 -> 3F800001 (exact).
- Exceptions:
  - 7F000000*40000000 -> 7F800000.
  - FF000000*40000000 -> FF800000.
  - 00800000*3F000000 -> 00000000.
  - 80000000*40400000 -> 80000000.
  - 7F800000*00000000 -> 00000000.
- Stall: issue 3 ops on consecutive cycles, drop en to 0 for 4 cycles after the first, then release -> outputs frozen during the stall, then all 3 results emerge in order, each exactly 3 en-cycles after issue, none lost or duplicated.
- Reset mid-flight: issue 2 valid ops, assert rstn=0 one cycle later for 1 cycle -> out_valid stays 0 with no stale result. The next op issued after reset completes normally with latency 3.
